// File: rtl/cpu_pkg.sv
// Shared RV32I decode constants: opcodes, ALU operation codes and the
// control bundle carried from decode into EX.
package cpu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       src_imm;
    logic       src_pc;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       jump;
  } ctrl_t;

  // funct7[5] only selects SUB on register-register ops; shifts honour it on both.
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic f7b5,
                                         input logic is_op);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_op && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: picks the format from the opcode and
// sign-extends the assembled immediate to DATA_WIDTH.
module imm_gen
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           i_instr,
  output logic [DATA_WIDTH-1:0] o_imm
);

  imm_type_e   w_type;
  logic [31:0] w_imm32;

  always_comb begin
    w_type = IMM_NONE;
    case (i_instr[6:0])
      OPC_LUI, OPC_AUIPC:                w_type = IMM_U;
      OPC_JAL:                           w_type = IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OPIMM:     w_type = IMM_I;
      OPC_BRANCH:                        w_type = IMM_B;
      OPC_STORE:                         w_type = IMM_S;
      default:                           w_type = IMM_NONE;
    endcase
  end

  always_comb begin
    w_imm32 = '0;
    case (w_type)
      IMM_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                        i_instr[11:8], 1'b0};
      IMM_U: w_imm32 = {i_instr[31:12], 12'b0};
      IMM_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                        i_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign o_imm = DATA_WIDTH'($signed(w_imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the IF/ID instruction, drives register-file
// read addresses, fills the ID/EX register and inserts load-use bubbles.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_valid,
  input  logic [31:0]           if_instr,
  input  logic [PC_WIDTH-1:0]   if_pc,
  output logic                  id_ready,
  output logic [4:0]            rf_rs1,
  output logic [4:0]            rf_rs2,
  input  logic [DATA_WIDTH-1:0] rf_rsdata1,
  input  logic [DATA_WIDTH-1:0] rf_rsdata2,
  input  logic                  ex_ready,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [PC_WIDTH-1:0]   ex_pc,
  output logic [DATA_WIDTH-1:0] ex_rs1data,
  output logic [DATA_WIDTH-1:0] ex_rs2data,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [4:0]            ex_rs1,
  output logic [4:0]            ex_rs2,
  output logic [4:0]            ex_rd,
  output logic [3:0]            ex_alu_op,
  output logic                  ex_src_imm,
  output logic                  ex_src_pc,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_reg_write,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic [2:0]            ex_funct3,
  output logic                  illegal
);

  logic [6:0]            w_opcode;
  logic [4:0]            w_rd;
  logic [2:0]            w_funct3;
  logic                  w_f7b5;
  logic [DATA_WIDTH-1:0] w_imm;
  ctrl_t                 w_ctrl;
  logic                  w_wr;
  logic                  w_use_rs1;
  logic                  w_use_rs2;
  logic                  w_illegal;
  logic                  w_load_use;

  logic                  r_valid;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [DATA_WIDTH-1:0] r_rs1data;
  logic [DATA_WIDTH-1:0] r_rs2data;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [4:0]            r_rs1;
  logic [4:0]            r_rs2;
  logic [4:0]            r_rd;
  logic [2:0]            r_funct3;
  ctrl_t                 r_ctrl;
  logic                  r_illegal;

  assign w_opcode = if_instr[6:0];
  assign w_rd     = if_instr[11:7];
  assign w_funct3 = if_instr[14:12];
  assign w_f7b5   = if_instr[30];
  assign rf_rs1   = if_instr[19:15];
  assign rf_rs2   = if_instr[24:20];

  imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
    .i_instr (if_instr),
    .o_imm   (w_imm)
  );

  always_comb begin
    w_ctrl        = '0;
    w_ctrl.alu_op = ALU_ADD;
    w_wr          = 1'b0;
    w_use_rs1     = 1'b0;
    w_use_rs2     = 1'b0;
    w_illegal     = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_ctrl.alu_op  = ALU_PASSB;
        w_ctrl.src_imm = 1'b1;
        w_wr           = 1'b1;
      end
      OPC_AUIPC: begin
        w_ctrl.src_imm = 1'b1;
        w_ctrl.src_pc  = 1'b1;
        w_wr           = 1'b1;
      end
      OPC_JAL: begin
        w_ctrl.src_imm = 1'b1;
        w_ctrl.src_pc  = 1'b1;
        w_ctrl.jump    = 1'b1;
        w_wr           = 1'b1;
      end
      OPC_JALR: begin
        w_ctrl.src_imm = 1'b1;
        w_ctrl.jump    = 1'b1;
        w_wr           = 1'b1;
        w_use_rs1      = 1'b1;
      end
      OPC_BRANCH: begin
        w_ctrl.branch = 1'b1;
        w_use_rs1     = 1'b1;
        w_use_rs2     = 1'b1;
      end
      OPC_LOAD: begin
        w_ctrl.src_imm  = 1'b1;
        w_ctrl.mem_read = 1'b1;
        w_wr            = 1'b1;
        w_use_rs1       = 1'b1;
      end
      OPC_STORE: begin
        w_ctrl.src_imm   = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_use_rs1        = 1'b1;
        w_use_rs2        = 1'b1;
      end
      OPC_OPIMM: begin
        w_ctrl.alu_op  = alu_sel(w_funct3, w_f7b5, 1'b0);
        w_ctrl.src_imm = 1'b1;
        w_wr           = 1'b1;
        w_use_rs1      = 1'b1;
      end
      OPC_OP: begin
        w_ctrl.alu_op = alu_sel(w_funct3, w_f7b5, 1'b1);
        w_wr          = 1'b1;
        w_use_rs1     = 1'b1;
        w_use_rs2     = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
    w_ctrl.reg_write = w_wr && (w_rd != 5'd0);
  end

  // Only operands the instruction really reads can create a hazard.
  assign w_load_use = r_valid && r_ctrl.mem_read && (r_rd != 5'd0) && if_valid &&
                      ((w_use_rs1 && (r_rd == rf_rs1)) || (w_use_rs2 && (r_rd == rf_rs2)));

  // A redirect discards the stalled instruction, so IF may advance regardless.
  assign id_ready = ex_ready && (flush || !w_load_use);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_rs1data <= '0;
      r_rs2data <= '0;
      r_imm     <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_funct3  <= '0;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (ex_ready) begin
      if (w_load_use) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
      end else begin
        r_valid   <= if_valid && !w_illegal;
        r_pc      <= if_pc;
        r_rs1data <= rf_rsdata1;
        r_rs2data <= rf_rsdata2;
        r_imm     <= w_imm;
        r_rs1     <= rf_rs1;
        r_rs2     <= rf_rs2;
        r_rd      <= w_rd;
        r_funct3  <= w_funct3;
        r_ctrl    <= w_ctrl;
        if (if_valid && w_illegal) r_illegal <= 1'b1;
      end
    end
  end

  assign ex_valid     = r_valid;
  assign ex_pc        = r_pc;
  assign ex_rs1data   = r_rs1data;
  assign ex_rs2data   = r_rs2data;
  assign ex_imm       = r_imm;
  assign ex_rs1       = r_rs1;
  assign ex_rs2       = r_rs2;
  assign ex_rd        = r_rd;
  assign ex_funct3    = r_funct3;
  assign ex_alu_op    = r_ctrl.alu_op;
  assign ex_src_imm   = r_ctrl.src_imm;
  assign ex_src_pc    = r_ctrl.src_pc;
  assign ex_mem_read  = r_ctrl.mem_read;
  assign ex_mem_write = r_ctrl.mem_write;
  assign ex_reg_write = r_ctrl.reg_write;
  assign ex_branch    = r_ctrl.branch;
  assign ex_jump      = r_ctrl.jump;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected ID/EX contents are queued as each
// instruction is presented and compared one cycle later.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, if_valid, ex_ready, flush;
  logic [31:0] if_instr, if_pc;
  logic        id_ready;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rsdata1, rf_rsdata2;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1data, ex_rs2data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_src_imm, ex_src_pc, ex_mem_read, ex_mem_write, ex_reg_write;
  logic        ex_branch, ex_jump;
  logic [2:0]  ex_funct3;
  logic        illegal;

  always #5 clk = ~clk;

  // Register-file stand-in: data encodes the address so captures are traceable.
  assign rf_rsdata1 = 32'hA000_0000 | {27'd0, rf_rs1};
  assign rf_rsdata2 = 32'hB000_0000 | {27'd0, rf_rs2};

  decode_stage #(.DATA_WIDTH(32), .PC_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rsdata1(rf_rsdata1), .rf_rsdata2(rf_rsdata2),
    .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1data(ex_rs1data), .ex_rs2data(ex_rs2data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .ex_src_imm(ex_src_imm), .ex_src_pc(ex_src_pc), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_funct3(ex_funct3), .illegal(illegal)
  );

  typedef struct {
    logic        vld;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic [6:0]  fl;
    logic [2:0]  f3;
  } exp_t;

  localparam logic [6:0] F_IMM = 7'b1000000, F_PC = 7'b0100000, F_MR = 7'b0010000;
  localparam logic [6:0] F_MW  = 7'b0001000, F_RW = 7'b0000100, F_BR = 7'b0000010;
  localparam logic [6:0] F_JP  = 7'b0000001;

  int   ntests = 0;
  int   nfail  = 0;
  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Imm of 'x means the instruction format carries no immediate.
  function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] pc,
                              input logic [31:0] imm, input logic [3:0] alu,
                              input logic [6:0] fl);
    exp_t e;
    e.vld = 1'b1;  e.pc = pc;  e.imm = imm;  e.alu = alu;  e.fl = fl;
    e.rd  = ins[11:7];  e.rs1 = ins[19:15];  e.rs2 = ins[24:20];  e.f3 = ins[14:12];
    e.d1  = 32'hA000_0000 | {27'd0, ins[19:15]};
    e.d2  = 32'hB000_0000 | {27'd0, ins[24:20]};
    return e;
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e = '{vld: 1'b0, pc: '0, d1: '0, d2: '0, imm: '0, rs1: '0, rs2: '0, rd: '0,
          alu: '0, fl: '0, f3: '0};
    return e;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v);
    if_instr = ins;  if_pc = pc;  if_valid = v;
    #1;
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    ntests++;
    assert (q.size() != 0) else begin
      nfail++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, ".vld"}, 32'(ex_valid), 32'(e.vld));
      if (e.vld) begin
        chk({tag, ".pc"},  ex_pc, e.pc);
        chk({tag, ".rd"},  32'(ex_rd), 32'(e.rd));
        chk({tag, ".rs1"}, 32'(ex_rs1), 32'(e.rs1));
        chk({tag, ".rs2"}, 32'(ex_rs2), 32'(e.rs2));
        chk({tag, ".d1"},  ex_rs1data, e.d1);
        chk({tag, ".d2"},  ex_rs2data, e.d2);
        chk({tag, ".alu"}, 32'(ex_alu_op), 32'(e.alu));
        chk({tag, ".f3"},  32'(ex_funct3), 32'(e.f3));
        chk({tag, ".flags"},
            32'({ex_src_imm, ex_src_pc, ex_mem_read, ex_mem_write, ex_reg_write,
                 ex_branch, ex_jump}), 32'(e.fl));
        if (!$isunknown(e.imm)) chk({tag, ".imm"}, ex_imm, e.imm);
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".vld"}, 32'(ex_valid), 32'd0);
    chk({tag, ".pc"}, ex_pc, 32'd0);
    chk({tag, ".data"}, ex_rs1data | ex_rs2data | ex_imm, 32'd0);
    chk({tag, ".idx"}, 32'({ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_alu_op}), 32'd0);
    chk({tag, ".flags"}, 32'({ex_src_imm, ex_src_pc, ex_mem_read, ex_mem_write,
                              ex_reg_write, ex_branch, ex_jump}), 32'd0);
    chk({tag, ".illegal"}, 32'(illegal), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;  ex_ready = 1'b1;  flush = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // addi x1,x0,5
    drive(32'h00500093, 32'h100, 1'b1);
    chk("addi.ready", 32'(id_ready), 32'd1);
    chk("addi.rfaddr", 32'({rf_rs1, rf_rs2}), 32'({5'd0, 5'd5}));
    q.push_back(mk(32'h00500093, 32'h100, 32'd5, 4'd0, F_IMM | F_RW));
    tick("addi");

    // lw x2,0(x1) then dependent add x3,x2,x1: exactly one bubble
    drive(32'h0000A103, 32'h104, 1'b1);
    q.push_back(mk(32'h0000A103, 32'h104, 32'd0, 4'd0, F_IMM | F_MR | F_RW));
    tick("lw");
    drive(32'h001101B3, 32'h108, 1'b1);
    chk("lu.ready0", 32'(id_ready), 32'd0);
    q.push_back(bubble());
    tick("lu.bubble");
    chk("lu.ready1", 32'(id_ready), 32'd1);
    q.push_back(mk(32'h001101B3, 32'h108, 'x, 4'd0, F_RW));
    tick("lu.add");

    // lw x0 followed by add reading x0: no stall
    drive(32'h0000A003, 32'h10C, 1'b1);
    q.push_back(mk(32'h0000A003, 32'h10C, 32'd0, 4'd0, F_IMM | F_MR));
    tick("lwx0");
    drive(32'h00000233, 32'h110, 1'b1);
    chk("x0.ready", 32'(id_ready), 32'd1);
    q.push_back(mk(32'h00000233, 32'h110, 'x, 4'd0, F_RW));
    tick("x0.add");

    // beq x1,x2,-8
    drive(32'hFE208CE3, 32'h114, 1'b1);
    q.push_back(mk(32'hFE208CE3, 32'h114, 32'hFFFF_FFF8, 4'd0, F_BR));
    tick("beq");

    // sub issues, then srai pending while EX stalls 3 cycles, then flush
    drive(32'h402082B3, 32'h118, 1'b1);
    q.push_back(mk(32'h402082B3, 32'h118, 'x, 4'd1, F_RW));
    tick("sub");
    drive(32'h4030D313, 32'h11C, 1'b1);
    ex_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold.ready", 32'(id_ready), 32'd0);
      q.push_back(mk(32'h402082B3, 32'h118, 'x, 4'd1, F_RW));
      tick("hold");
    end
    flush = 1'b1;
    #1;
    chk("hold.flush.ready", 32'(id_ready), 32'd0);
    q.push_back(bubble());
    tick("hold.flush");
    flush = 1'b0;  ex_ready = 1'b1;
    #1;
    q.push_back(mk(32'h4030D313, 32'h11C, 32'h0000_0403, 4'd7, F_IMM | F_RW));
    tick("srai");

    // flush coinciding with a load-use hazard
    drive(32'h0000A103, 32'h120, 1'b1);
    q.push_back(mk(32'h0000A103, 32'h120, 32'd0, 4'd0, F_IMM | F_MR | F_RW));
    tick("lw2");
    flush = 1'b1;
    drive(32'h001101B3, 32'h124, 1'b1);
    chk("lu.flush.ready", 32'(id_ready), 32'd1);
    q.push_back(bubble());
    tick("lu.flush");
    flush = 1'b0;
    #1;
    chk("lu.flush.after", 32'(id_ready), 32'd1);
    q.push_back(mk(32'h001101B3, 32'h124, 'x, 4'd0, F_RW));
    tick("lu.flush.add");

    // remaining formats: lui, jal, sw (negative offset), jalr, auipc
    drive(32'h123453B7, 32'h128, 1'b1);
    q.push_back(mk(32'h123453B7, 32'h128, 32'h1234_5000, 4'd10, F_IMM | F_RW));
    tick("lui");
    drive(32'h010000EF, 32'h12C, 1'b1);
    q.push_back(mk(32'h010000EF, 32'h12C, 32'd16, 4'd0, F_IMM | F_PC | F_RW | F_JP));
    tick("jal");
    drive(32'hFE20AE23, 32'h130, 1'b1);
    q.push_back(mk(32'hFE20AE23, 32'h130, 32'hFFFF_FFFC, 4'd0, F_IMM | F_MW));
    tick("sw");
    drive(32'h008280E7, 32'h134, 1'b1);
    q.push_back(mk(32'h008280E7, 32'h134, 32'd8, 4'd0, F_IMM | F_RW | F_JP));
    tick("jalr");
    drive(32'hFFFFF297, 32'h138, 1'b1);
    q.push_back(mk(32'hFFFFF297, 32'h138, 32'hFFFF_F000, 4'd0, F_IMM | F_PC | F_RW));
    tick("auipc");

    // illegal instruction: bubble, sticky flag
    chk("ill.pre", 32'(illegal), 32'd0);
    drive(32'hFFFFFFFF, 32'h13C, 1'b1);
    q.push_back(bubble());
    tick("ill");
    chk("ill.set", 32'(illegal), 32'd1);
    drive(32'h00500093, 32'h140, 1'b1);
    q.push_back(mk(32'h00500093, 32'h140, 32'd5, 4'd0, F_IMM | F_RW));
    tick("ill.next");
    chk("ill.sticky", 32'(illegal), 32'd1);
    drive(32'h00500093, 32'h144, 1'b0);
    q.push_back(bubble());
    tick("idle");

    // reset while EX is stalled
    ex_ready = 1'b0;  rst_n = 1'b0;
    drive(32'h00500093, 32'h148, 1'b1);
    @(posedge clk);
    #1;
    chk_zero("rst.stall");
    rst_n = 1'b1;  ex_ready = 1'b1;
    #1;
    q.push_back(mk(32'h00500093, 32'h148, 32'd5, 4'd0, F_IMM | F_RW));
    tick("restart");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
